// File: rtl/cpu_pkg.sv
// Shared definitions for the two-stage pipeline: D_BUS field layout, opcodes
// and the fetch sequencing states. Fetch and execute both import this.
package cpu_pkg;

    localparam logic [3:0] OP_JMP = 4'hF;
    localparam logic [3:0] OP_JNC = 4'hE;
    localparam logic [3:0] OP_NOP = 4'h8;

    localparam logic [7:0] NOP_WORD = {OP_NOP, 4'h0};

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } fsm_state_e;

    function automatic logic [3:0] opcode_of(input logic [7:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] imm_of(input logic [7:0] word);
        return word[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/fetch_issue_program_counter.sv
// Program counter with load-over-increment priority; wraps naturally at PC_W bits.
module program_counter #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        // NOTE: default assigned first so every path drives pc_d and no latch is inferred.
        pc_d = pc_q;
        if (load) begin
            pc_d = target;
        end else if (inc) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_issue.sv
// Fetch/issue stage: drives one word per cycle onto D_BUS, resolves JMP/JNC
// from the word already on D_BUS, and inserts a single bubble after a taken branch.
module fetch_issue #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [7:0]      NOP_WORD = 8'h80
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    input  logic            cflag,
    input  logic [7:0]      rom_data,
    output logic [PC_W-1:0] rom_addr,
    output logic [7:0]      D_BUS,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic [7:0]      issue_cnt
);

    import cpu_pkg::*;

    fsm_state_e state_q, state_d;
    logic [7:0] dbus_q, dbus_d;
    logic       flush_q, flush_d;
    logic [7:0] cnt_q, cnt_d;

    logic            taken;
    logic            issue;
    logic            pc_load;
    logic            pc_inc;
    logic [PC_W-1:0] target;
    logic [3:0]      opcode;

    assign opcode = opcode_of(dbus_q);
    assign taken  = (opcode == OP_JMP) | ((opcode == OP_JNC) & ~cflag);
    assign issue  = run | (step & (state_q == IDLE));
    assign target = PC_W'(imm_of(dbus_q));

    program_counter #(
        .PC_W    (PC_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clock (clock),
        .reset (reset),
        .load  (pc_load),
        .inc   (pc_inc),
        .target(target),
        .pc    (pc)
    );

    // A resolving branch wins over issue; the word fetched at the old pc is dropped.
    always_comb begin
        dbus_d  = NOP_WORD;
        flush_d = 1'b1;
        cnt_d   = cnt_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (taken) begin
            pc_load = 1'b1;
        end else if (issue) begin
            dbus_d  = rom_data;
            flush_d = 1'b0;
            cnt_d   = cnt_q + 8'd1;
            pc_inc  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (run) begin
                    state_d = RUN;
                end else if (!step) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dbus_q  <= NOP_WORD;
            flush_q <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dbus_q  <= dbus_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_addr  = pc;
    assign D_BUS     = dbus_q;
    assign flush     = flush_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_issue.sv
// Scoreboard bench for fetch_issue: stimulus queues the hand-computed outputs
// expected after each edge; a monitor pops and compares one entry per cycle.
module tb_fetch_issue;

    logic       clock;
    logic       reset;
    logic       run;
    logic       step;
    logic       cflag;
    logic [7:0] rom_data;
    logic [3:0] rom_addr;
    logic [7:0] D_BUS;
    logic [3:0] pc;
    logic       flush;
    logic [7:0] issue_cnt;

    logic [7:0] rom [16];

    typedef struct {
        string      name;
        logic [7:0] dbus;
        logic       flush;
        logic [3:0] pc;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    fetch_issue #(
        .PC_W    (4),
        .RESET_PC(4'h0),
        .NOP_WORD(8'h80)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .cflag    (cflag),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .D_BUS    (D_BUS),
        .pc       (pc),
        .flush    (flush),
        .issue_cnt(issue_cnt)
    );

    assign rom_data = rom[rom_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs apply for one cycle; the expectation describes outputs after the next edge.
    task automatic drive(input logic r, input logic ru, input logic st, input logic cf,
                         input logic [7:0] e_dbus, input logic e_flush,
                         input logic [3:0] e_pc, input logic [7:0] e_cnt, input string nm);
        exp_t e;
        e.name  = nm;
        e.dbus  = e_dbus;
        e.flush = e_flush;
        e.pc    = e_pc;
        e.cnt   = e_cnt;
        reset = r;
        run   = ru;
        step  = st;
        cflag = cf;
        sb_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < 16; i++) rom[i] = val;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".dbus"},  32'(D_BUS),     32'(e.dbus));
                check({e.name, ".flush"}, 32'(flush),     32'(e.flush));
                check({e.name, ".pc"},    32'(pc),        32'(e.pc));
                check({e.name, ".cnt"},   32'(issue_cnt), 32'(e.cnt));
                check({e.name, ".addr"},  32'(rom_addr),  32'(e.pc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        bad++;
        $display("FAIL watchdog: time limit reached with %0d entries pending", sb_q.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stimulus
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        cflag = 1'b0;
        fill_rom(8'h00);
        @(posedge clock);
        #2;

        // Straight-line run, then JMP 2 with one bubble
        fill_rom(8'h00);
        rom[0] = 8'h30; rom[1] = 8'h51; rom[2] = 8'h90; rom[3] = 8'hB7;
        rom[4] = 8'h12; rom[5] = 8'hF2;
        drive(1, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset");
        drive(0, 1, 0, 0, 8'h30, 0, 4'h1, 8'd1, "run0");
        drive(0, 1, 0, 0, 8'h51, 0, 4'h2, 8'd2, "run1");
        drive(0, 1, 0, 0, 8'h90, 0, 4'h3, 8'd3, "run2");
        drive(0, 1, 0, 0, 8'hB7, 0, 4'h4, 8'd4, "run3");
        drive(0, 1, 0, 0, 8'h12, 0, 4'h5, 8'd5, "run4");
        drive(0, 1, 0, 0, 8'hF2, 0, 4'h6, 8'd6, "jmp_on_bus");
        drive(0, 1, 0, 0, 8'h80, 1, 4'h2, 8'd6, "jmp_bubble");
        drive(0, 1, 0, 0, 8'h90, 0, 4'h3, 8'd7, "jmp_target");

        // JNC not taken (cflag=1), JMP ignores cflag, JNC taken (cflag=0)
        fill_rom(8'h00);
        rom[0] = 8'hF6; rom[6] = 8'hE9; rom[7] = 8'h77; rom[8] = 8'hF6; rom[9] = 8'h5A;
        drive(1, 1, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset_with_run");
        drive(0, 1, 0, 0, 8'hF6, 0, 4'h1, 8'd1, "jmp6");
        drive(0, 1, 0, 0, 8'h80, 1, 4'h6, 8'd1, "jmp6_bubble");
        drive(0, 1, 0, 0, 8'hE9, 0, 4'h7, 8'd2, "jnc_on_bus");
        drive(0, 1, 0, 1, 8'h77, 0, 4'h8, 8'd3, "jnc_not_taken");
        drive(0, 1, 0, 1, 8'hF6, 0, 4'h9, 8'd4, "jmp6_again");
        drive(0, 1, 0, 1, 8'h80, 1, 4'h6, 8'd4, "jmp_ignores_cflag");
        drive(0, 1, 0, 0, 8'hE9, 0, 4'h7, 8'd5, "jnc_on_bus2");
        drive(0, 1, 0, 0, 8'h80, 1, 4'h9, 8'd5, "jnc_taken");
        drive(0, 1, 0, 0, 8'h5A, 0, 4'hA, 8'd6, "jnc_target");

        // PC wrap F -> 0
        fill_rom(8'h00);
        rom[0] = 8'hFF; rom[15] = 8'h3C;
        drive(1, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset3");
        drive(0, 1, 0, 0, 8'hFF, 0, 4'h1, 8'd1, "jmpF");
        drive(0, 1, 0, 0, 8'h80, 1, 4'hF, 8'd1, "jmpF_bubble");
        drive(0, 1, 0, 0, 8'h3C, 0, 4'h0, 8'd2, "pc_wrap");
        drive(0, 1, 0, 0, 8'hFF, 0, 4'h1, 8'd3, "after_wrap");

        // Tight loop: JMP to own address alternates with bubble
        fill_rom(8'h00);
        rom[0] = 8'hF3; rom[3] = 8'hF3;
        drive(1, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset4");
        drive(0, 1, 0, 0, 8'hF3, 0, 4'h1, 8'd1, "loop_entry");
        drive(0, 1, 0, 0, 8'h80, 1, 4'h3, 8'd1, "loop_b0");
        drive(0, 1, 0, 0, 8'hF3, 0, 4'h4, 8'd2, "loop_j1");
        drive(0, 1, 0, 0, 8'h80, 1, 4'h3, 8'd2, "loop_b1");
        drive(0, 1, 0, 0, 8'hF3, 0, 4'h4, 8'd3, "loop_j2");
        drive(0, 1, 0, 0, 8'h80, 1, 4'h3, 8'd3, "loop_b2");

        // Single step: held step issues once, re-arm after release
        fill_rom(8'h00);
        rom[0] = 8'h30; rom[1] = 8'h51;
        drive(1, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset5");
        drive(0, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "idle");
        drive(0, 0, 1, 0, 8'h30, 0, 4'h1, 8'd1, "step_issue");
        drive(0, 0, 1, 0, 8'h80, 1, 4'h1, 8'd1, "step_held1");
        drive(0, 0, 1, 0, 8'h80, 1, 4'h1, 8'd1, "step_held2");
        drive(0, 0, 0, 0, 8'h80, 1, 4'h1, 8'd1, "step_release");
        drive(0, 0, 1, 0, 8'h51, 0, 4'h2, 8'd2, "step_rearm");
        drive(0, 0, 0, 0, 8'h80, 1, 4'h2, 8'd2, "step_done");

        // JMP resolves although run drops; reset discards an in-flight JNC
        fill_rom(8'h00);
        rom[0] = 8'hF5; rom[5] = 8'hE9;
        drive(1, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset6");
        drive(0, 1, 0, 0, 8'hF5, 0, 4'h1, 8'd1, "jmp5");
        drive(0, 0, 0, 0, 8'h80, 1, 4'h5, 8'd1, "jmp_run_drop");
        drive(0, 0, 0, 0, 8'h80, 1, 4'h5, 8'd1, "stopped_hold");
        drive(0, 1, 0, 0, 8'hE9, 0, 4'h6, 8'd2, "jnc_inflight");
        drive(1, 1, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset_mid_jnc");
        drive(0, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "post_reset_no_branch");

        // ROM words equal to the bubble are counted; counter wraps 255 -> 0
        fill_rom(8'h80);
        drive(1, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "reset7");
        for (int i = 0; i < 256; i++) begin
            drive(0, 1, 0, 0, 8'h80, 0, 4'(i + 1), 8'(i + 1), $sformatf("cnt%0d", i + 1));
        end
        drive(0, 0, 0, 0, 8'h80, 1, 4'h0, 8'd0, "cnt_wrapped_idle");

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
First stage of the 2-stage pipeline.
- Owns the program counter and reads program memory.
- Drives the 8-bit D_BUS instruction word (opcode [7:4], immediate/target [3:0]) that the execute stage consumes. It is the producer end of the D_BUS interface.
- Resolves JMP/JNC branches from the word currently on D_BUS using the execute stage's cflag. It flushes the wrong-path fetch by issuing a bubble.

Parameters:
PC_W, 4, program counter / ROM address width; target field is D_BUS[3:0], zero-extended to PC_W.
RESET_PC, 0, PC value after reset.
NOP_WORD, 8'h80, bubble word (opcode 4'b1000, decoded by execute as no register, flag or port load).

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
run  in  1  free-run enable: issue one instruction per cycle while high
step  in  1  single-cycle pulse: issue exactly one instruction while run=0
cflag  in  1  carry flag from execute stage, valid during the cycle a word occupies D_BUS
rom_data  in  8  program memory read data, combinational from rom_addr
rom_addr  out  PC_W  program memory address (= pc, combinational)
D_BUS  out  8  registered instruction word to execute stage
pc  out  PC_W  current program counter
flush  out  1  registered; high while D_BUS holds a bubble
issue_cnt  out  8  count of real (non-bubble) instructions issued, wraps 255->0

Behaviour:
- Reset (reset=1 at a rising edge, regardless of other inputs):
  - pc=RESET_PC, D_BUS=NOP_WORD, flush=1, issue_cnt=0, state=IDLE.
  - Reset asserted mid-operation discards the in-flight word; no branch from it is taken.
- Every D_BUS word is present for exactly one cycle. The execute stage never sees a word twice.
- taken = (D_BUS[7:4]==4'hF) | (D_BUS[7:4]==4'hE & ~cflag). Evaluated every cycle, independent of run/step. A JMP/JNC already on D_BUS always resolves.
- issue = run | (step & state==IDLE).
- Per-edge priority:
  1. taken: pc<=target; D_BUS<=NOP_WORD; flush<=1. The word fetched at the old pc is discarded. Branch penalty is exactly 1 bubble.
  2. else issue: D_BUS<=rom_data; pc<=pc+1 (wraps 2^PC_W-1 -> 0); flush<=0; issue_cnt+=1.
  3. else: D_BUS<=NOP_WORD; flush<=1; pc holds.
- Latency: rom_addr=pc in cycle N, so the word is on D_BUS in cycle N+1 and its branch resolves at edge ending N+1.
- A bubble follows every taken branch, so back-to-back branch resolution cannot occur.
- A branch whose target equals its own address is legal (tight loop): JMP, bubble, JMP, bubble, ...
- FSM (step/run sequencing):
  - IDLE: run=1 -> RUN. step=1 and run=0 -> STEP.
  - RUN: run=0 -> IDLE.
  - STEP: one issue is consumed. Next cycle -> IDLE if step=0, stay in STEP (no further issue) while step is held high.
  - A held step issues only one instruction. Re-arming requires step to go low.
- step is ignored in RUN. run=1 overrides STEP (-> RUN).
- NOP_WORD issued by fetch is not counted in issue_cnt. A rom_data word equal to NOP_WORD is counted.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_JMP=4'hF, OP_JNC=4'hE, OP_NOP=4'h8
  - NOP_WORD
  - FSM state enum {IDLE, RUN, STEP}
  - the D_BUS field positions (opcode [7:4], imm [3:0])
- The execute stage imports the same package.
- One sub-module, program_counter: holds pc, with load (target) / increment / hold controls, wrapping at PC_W.

Test Plan:
- Reset then run=1, ROM[0..3]={30,51,90,B7}: D_BUS = 80,30,51,90,B7 on consecutive cycles. issue_cnt=4, pc=4.
- ROM[5]=F2 (JMP 2), run=1: cycle after F2 on D_BUS, D_BUS=80 and flush=1. Next D_BUS=ROM[2], pc=3.
- ROM[6]=E9 with cflag=1 -> no branch, next D_BUS=ROM[7]. Repeat with cflag=0 -> bubble, then ROM[9].
- pc=F, run=1: next pc=0, D_BUS=ROM[F], then ROM[0] (wrap). ROM[3]=F3 tight loop: D_BUS alternates F3/80 indefinitely.
- run=0, step held high 3 cycles from IDLE: exactly one word issued, issue_cnt+1. Then 80 bubbles. step low then high issues the next word.
- JMP on D_BUS while run drops to 0 in same cycle: pc<=target still. reset=1 while JNC on D_BUS with cflag=0: pc=0, D_BUS=80, issue_cnt=0.
